line_burst_adaptor: RTL and testbench

Memory-side responder for the cache arbiter's L2/memory port. Accepts 256-bit line read/write requests with a level-held request and one-cycle `resp_o` handshake. Converts each request into a 4-beat, 64-bit burst on the physical memory bus. Returns assembled read lines to the arbiter.

---
 rtl/line_burst_adaptor.sv | 141 ++++++++++++++
 tb/tb_line_burst_adaptor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adaptor.sv
// Line-to-burst memory responder: turns 256-bit line read/write requests into 4-beat 64-bit bursts.
// Optional macro LBA_RESP_BYPASS_EN: drop the DONE state and signal completion combinationally on the last beat.
module line_burst_adaptor #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      read_i,
  input  logic                      write_i,
  input  logic [31:0]               address_i,
  input  logic [BEATS*BEAT_W-1:0]   line_i,
  output logic [BEATS*BEAT_W-1:0]   line_o,
  output logic                      resp_o,
  output logic [31:0]               mem_address_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic [BEAT_W-1:0]         burst_o,
  input  logic [BEAT_W-1:0]         burst_i,
  input  logic                      mem_resp_i
);

  localparam int unsigned LINE_W = BEATS * BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFS_W  = 5;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [LINE_W-1:0]   wbuf;
  logic [LINE_W-1:0]   rbuf;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_done;
  logic                last_beat;
  logic                unused_addr_bits;

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign last_beat = (state == S_RD || state == S_WR) && mem_resp_i && (cnt == LAST_BEAT);
  // The final beat bypasses the buffer so the line is complete at the edge that ends the burst.
  assign line_done = {burst_i, rbuf[LINE_W-BEAT_W-1:0]};
  assign unused_addr_bits = ^address_i[OFS_W-1:0];

`ifdef LBA_RESP_BYPASS_EN
  assign resp_o = last_beat;
  assign line_o = (state == S_RD && last_beat) ? line_done : line_q;
`else
  logic resp_q;
  assign resp_o = resp_q;
  assign line_o = line_q;
`endif

  // Control FSM with registered bus outputs; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      wbuf          <= '0;
      rbuf          <= '0;
      line_q        <= '0;
      mem_address_o <= '0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      burst_o       <= '0;
`ifndef LBA_RESP_BYPASS_EN
      resp_q        <= 1'b0;
`endif
    end else begin
`ifndef LBA_RESP_BYPASS_EN
      resp_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (read_i) begin
            state         <= S_RD;
            cnt           <= '0;
            mem_address_o <= {address_i[31:OFS_W], OFS_W'(0)};
            mem_read_o    <= 1'b1;
          end else if (write_i) begin
            state         <= S_WR;
            cnt           <= '0;
            mem_address_o <= {address_i[31:OFS_W], OFS_W'(0)};
            wbuf          <= line_i;
            burst_o       <= line_i[BEAT_W-1:0];
            mem_write_o   <= 1'b1;
          end
        end
        S_RD: begin
          if (mem_resp_i) begin
            rbuf[BEAT_W*int'(cnt) +: BEAT_W] <= burst_i;
            if (cnt == LAST_BEAT) begin
              cnt        <= '0;
              mem_read_o <= 1'b0;
              line_q     <= line_done;
`ifdef LBA_RESP_BYPASS_EN
              state      <= S_IDLE;
`else
              state      <= S_DONE;
              resp_q     <= 1'b1;
`endif
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        S_WR: begin
          if (mem_resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt         <= '0;
              mem_write_o <= 1'b0;
              burst_o     <= '0;
`ifdef LBA_RESP_BYPASS_EN
              state       <= S_IDLE;
`else
              state       <= S_DONE;
              resp_q      <= 1'b1;
`endif
            end else begin
              cnt     <= cnt_nxt;
              burst_o <= wbuf[BEAT_W*int'(cnt_nxt) +: BEAT_W];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: table of line transactions, a bench-side memory responder
// and a completion scoreboard, plus hand-written reset and stray-acknowledge sequences.
module tb_line_burst_adaptor;

`ifdef LBA_RESP_BYPASS_EN
  localparam int RESP_OFS = 1;
`else
  localparam int RESP_OFS = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         read_i, write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  mem_address_o;
  logic         mem_read_o, mem_write_o;
  logic [63:0]  burst_o, burst_i;
  logic         mem_resp_i;

  always #5 clk = ~clk;

  line_burst_adaptor dut (
    .clk(clk), .reset_n(reset_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .burst_o(burst_o), .burst_i(burst_i), .mem_resp_i(mem_resp_i)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [255:0] rdata;
    logic [15:0]  waits;     // 4-bit wait count before each beat
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    int           exp_cyc;   // resp_o cycle with the registered DONE state
  } vec_t;

  typedef struct {
    logic [255:0] line;
    int           cyc;
  } sb_t;

  vec_t         vecs[7];
  sb_t          sb_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [255:0] cur_line = '0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [255:0] line, input logic [255:0] rdata,
                              input logic [15:0] waits, input logic [31:0] exp_addr,
                              input logic [255:0] exp_line, input int exp_cyc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.line = line; v.rdata = rdata; v.waits = waits;
    v.exp_addr = exp_addr; v.exp_line = exp_line; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one line transaction, acting as the arbiter and the memory; request drops after resp_o.
  task automatic run_txn(input vec_t v);
    int   beats;
    int   waits_left;
    bit   done_burst;
    bit   resp_seen;
    bit   in_burst;
    sb_t  e;
    sb_t  got;
    tick();
    read_i = v.rd; write_i = v.wr; address_i = v.addr; line_i = v.line;
    mem_resp_i = 1'b0; reset_n = 1'b0;
    e.line = v.exp_line;
    e.cyc  = v.exp_cyc - RESP_OFS;
    sb_q.push_back(e);
    beats = 0; done_burst = 0; resp_seen = 0;
    waits_left = int'(v.waits[3:0]);
    @(negedge clk);
    chk("start_rd", 256'(mem_read_o), 256'(1'b0));
    chk("start_wr", 256'(mem_write_o), 256'(1'b0));
    for (int c = 1; c <= e.cyc + 2; c++) begin
      tick();
      if (c == e.cyc + 1) begin
        read_i = 1'b0; write_i = 1'b0;
      end
      mem_resp_i = 1'b0;
      burst_i = {$urandom, $urandom};
      if (!done_burst) begin
        if (waits_left > 0) waits_left--;
        else begin
          mem_resp_i = 1'b1;
          burst_i = v.rdata[64*beats +: 64];
        end
      end
      @(negedge clk);
      in_burst = !done_burst;
      chk("mem_read", 256'(mem_read_o), 256'(in_burst && v.rd));
      chk("mem_write", 256'(mem_write_o), 256'(in_burst && !v.rd));
      if (in_burst) chk("mem_addr", 256'(mem_address_o), 256'(v.exp_addr));
      if (in_burst && !v.rd) chk("burst_o", 256'(burst_o), 256'(v.line[64*beats +: 64]));
      chk("line_o", line_o, (c >= e.cyc) ? v.exp_line : cur_line);
      if (resp_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL resp_extra actual=1 required=0 cycle=%0d", c);
        end else begin
          got = sb_q.pop_front();
          chk("resp_cycle", 256'(c), 256'(got.cyc));
          chk("resp_line", line_o, got.line);
          resp_seen = 1;
        end
      end
      if (mem_resp_i && !done_burst) begin
        beats++;
        if (beats == 4) done_burst = 1;
        else waits_left = int'(v.waits[4*beats +: 4]);
      end
    end
    if (!resp_seen) begin
      checks++;
      failures++;
      $display("FAIL resp_missing actual=0 required=1");
      sb_q.delete();
    end
    cur_line = v.exp_line;
    mem_resp_i = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(1, 0, 32'h0000_1234, '0,
                 {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'h0000,
                 32'h0000_1220, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 5);
    vecs[1] = mk(0, 1, 32'h4000_0008, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, '0,
                 16'h0200, 32'h4000_0000,
                 {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 7);
    vecs[2] = mk(1, 1, 32'h0000_0040, {4{64'hF0F0_1234_5678_0F0F}},
                 {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978},
                 16'h0000, 32'h0000_0040,
                 {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978}, 5);
    vecs[3] = mk(1, 0, 32'hFFFF_FFFF, '0,
                 {{16{4'hA}}, {8{8'h5A}}, {8{8'h3C}}, {8{8'hC3}}}, 16'h1301,
                 32'hFFFF_FFE0, {{16{4'hA}}, {8{8'h5A}}, {8{8'h3C}}, {8{8'hC3}}}, 10);
    vecs[4] = mk(0, 1, 32'h0000_0100,
                 {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000},
                 '0, 16'h1010, 32'h0000_0100,
                 {{16{4'hA}}, {8{8'h5A}}, {8{8'h3C}}, {8{8'hC3}}}, 7);
    vecs[5] = mk(1, 0, 32'h0000_009F, '0,
                 {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000},
                 16'h0000, 32'h0000_0080,
                 {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000}, 5);
    vecs[6] = mk(1, 0, 32'h0000_2040, '0,
                 {64'hBEEF_0000_0000_0004, 64'hBEEF_0000_0000_0003, 64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0001},
                 16'h0000, 32'h0000_2040,
                 {64'hBEEF_0000_0000_0004, 64'hBEEF_0000_0000_0003, 64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0001}, 5);

    reset_n = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; line_i = '0;
    burst_i = '0; mem_resp_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_line", line_o, '0);
    chk("rst_resp", 256'(resp_o), '0);
    chk("rst_addr", 256'(mem_address_o), '0);
    chk("rst_rdwr", 256'({mem_read_o, mem_write_o}), '0);
    chk("rst_burst", 256'(burst_o), '0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Stray acknowledges while idle must not start or complete anything.
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      chk("stray_resp", 256'(resp_o), '0);
      chk("stray_rdwr", 256'({mem_read_o, mem_write_o}), '0);
      chk("stray_line", line_o, cur_line);
    end
    mem_resp_i = 1'b0;
    run_txn(vecs[5]);

    // Reset in the middle of a read after two beats, request kept high.
    tick();
    read_i = 1'b1; address_i = 32'h0000_2040;
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
    end
    tick();
    mem_resp_i = 1'b0;
    @(negedge clk);
    chk("mid_rd", 256'(mem_read_o), 256'(1'b1));
    reset_n = 1'b1;
    #1;
    chk("mid_rst_rdwr", 256'({mem_read_o, mem_write_o}), '0);
    chk("mid_rst_resp", 256'(resp_o), '0);
    chk("mid_rst_addr", 256'(mem_address_o), '0);
    chk("mid_rst_burst", 256'(burst_o), '0);
    chk("mid_rst_line", line_o, '0);
    cur_line = '0;
    run_txn(vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
